// File: rtl/serial_priority_encoder_if.sv
// Handshake bundle for the serial priority encoder: request vector in, one index beat out.
// The master side produces vectors and consumes beats; the slave side is the encoder.
interface serial_priority_encoder_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_onehot;
  logic             out_last;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_last
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_last
  );
endinterface

// File: rtl/serial_priority_encoder.sv
// Serial priority encoder: latches a multi-hot vector and emits the index of each
// set bit, lowest first, one per output handshake, with its one-hot alongside.
module serial_priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  serial_priority_encoder_if.slave   bus,
  output logic                       busy,
  output logic                       zero_err
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_err_q, zero_err_d;

  logic [WIDTH-1:0] lowest;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             accept;
  logic             beat;

  // Every beat output is a pure decode of pending_q, so it holds steady under backpressure.
  always_comb begin
    lowest = pending_q & (~pending_q + WIDTH'(1));
    last   = (pending_q & (pending_q - WIDTH'(1))) == '0;
    idx    = '0;
    for (int i = 0; i < WIDTH; i++)
      if (lowest[i]) idx = idx | IDX_W'(i);
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign beat   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_vec != '0) begin
            pending_d = bus.in_vec;
            state_d   = EMIT;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (beat) begin
          pending_d = pending_q & ~lowest;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

  // pending_q is zero whenever IDLE, so idx and lowest are already zero there.
  assign bus.in_ready   = (state_q == IDLE) & en & ~rst;
  assign bus.out_valid  = (state_q == EMIT);
  assign bus.out_idx    = idx;
  assign bus.out_onehot = lowest;
  assign bus.out_last   = (state_q == EMIT) & last;
  assign busy           = (state_q == EMIT);
  assign zero_err       = zero_err_q;
endmodule

// File: tb/tb_serial_priority_encoder.sv
// Scoreboard bench for serial_priority_encoder: accepted vectors expand into queued
// index beats; a negedge monitor compares every output against the queue head.
module tb_serial_priority_encoder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, en;
  logic busy, zero_err;

  serial_priority_encoder_if #(.WIDTH(W)) bus ();

  serial_priority_encoder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .zero_err (zero_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [W-1:0] oh;
    bit          last;
  } beat_t;

  beat_t sb[$];
  int    errs   = 0;
  int    checks = 0;
  bit    zexp   = 1'b0;
  bit    exp_rdy;
  bit    exp_vld;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: each set bit, ascending, becomes one beat; the highest is the last.
  function automatic void push_vec(input logic [W-1:0] v);
    int hi = -1;
    for (int i = 0; i < W; i++) if (v[i]) hi = i;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        beat_t b;
        b.idx  = i;
        b.oh   = '0;
        b.oh[i] = 1'b1;
        b.last = (i == hi);
        sb.push_back(b);
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_rdy = en && !rst && (sb.size() == 0);
    exp_vld = (sb.size() != 0);
    chk("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
    chk("busy",      64'(busy),          64'(exp_vld));
    chk("zero_err",  64'(zero_err),      64'(zexp));
    if (exp_vld) begin
      chk("out_idx",    64'(bus.out_idx),    64'(sb[0].idx));
      chk("out_onehot", 64'(bus.out_onehot), 64'(sb[0].oh));
      chk("out_last",   64'(bus.out_last),   64'(sb[0].last));
    end else begin
      chk("idle_idx",    64'(bus.out_idx),    64'(0));
      chk("idle_onehot", 64'(bus.out_onehot), 64'(0));
      chk("idle_last",   64'(bus.out_last),   64'(0));
    end
    zexp = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      if (exp_vld && bus.out_ready) void'(sb.pop_front());
      if (bus.in_valid && exp_rdy) begin
        if (bus.in_vec == '0) zexp = 1'b1;
        else push_vec(bus.in_vec);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // A5: indices 0,2,5,7 back to back
    bus.in_valid = 1'b1; bus.in_vec = 8'hA5;
    cyc();
    bus.in_valid = 1'b0;
    repeat (6) cyc();

    // 81 with a 3-cycle stall on the first beat
    bus.in_valid = 1'b1; bus.in_vec = 8'h81; bus.out_ready = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    bus.out_ready = 1'b1;
    repeat (4) cyc();

    // all-zero vector
    bus.in_valid = 1'b1; bus.in_vec = 8'h00;
    cyc();
    bus.in_valid = 1'b0;
    repeat (2) cyc();

    // en gating, then FF drained with en dropped mid-way
    en = 1'b0; bus.in_valid = 1'b1; bus.in_vec = 8'hFF;
    repeat (3) cyc();
    en = 1'b1;
    cyc();
    bus.in_valid = 1'b0; en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;

    // F0 with reset while idx 5 is presented
    bus.in_valid = 1'b1; bus.in_vec = 8'hF0;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // randomized traffic
    repeat (3000) begin
      int sel;
      logic [W-1:0] v;
      sel = $urandom_range(0, 7);
      v = W'($urandom);
      if (sel == 0) v = '0;
      else if (sel == 1) begin
        v = '0;
        v[$urandom_range(0, W-1)] = 1'b1;
      end
      bus.in_vec    = v;
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      en            = ($urandom_range(0, 7) != 0);
      rst           = ($urandom_range(0, 99) == 0);
      cyc();
    end

    rst = 1'b0; en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (20) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
